// File: rtl/object_scanline_sequencer_pkg.sv
// object_scanline_sequencer_pkg: OBM object layout, table size and the shared scanline hit test.
package object_scanline_sequencer_pkg;

   localparam int NUM_OBJECTS = 64;

   typedef struct packed {
      logic [7:0] x;
      logic [7:0] y;
      logic [7:0] tile;
      logic [3:0] palette;
      logic       flip_x;
      logic       flip_y;
      logic [1:0] layer;
   } obm_object_t;

   // 9-bit compare so objects near the bottom edge never wrap onto the top lines
   function automatic logic object_on_line(input logic [7:0] y, input obm_object_t obj);
      return ({1'b0, y} >= {1'b0, obj.y}) && ({1'b0, y} <= {1'b0, obj.y} + 9'd7);
   endfunction

endpackage

// File: rtl/object_scanline_sequencer.sv
// object_scanline_sequencer: per-line clear, OBM scan and load issue for object_scanline.
// Define OBJ_LIMIT_EN to cap loads per line at MAX_PER_LINE and report overflow_o.
module object_scanline_sequencer
   import object_scanline_sequencer_pkg::*;
#(
   parameter int NUM_OBJECTS = object_scanline_sequencer_pkg::NUM_OBJECTS
`ifdef OBJ_LIMIT_EN
   , parameter int MAX_PER_LINE = 8
`endif
) (
   input  logic                           gpu_clk,
   input  logic                           rst,
   input  logic                           line_start_i,
   input  logic [7:0]                     next_y_i,
   output logic [$clog2(NUM_OBJECTS)-1:0] obm_addr_o,
   input  obm_object_t                    obm_object_i,
   input  logic                           scanline_ready_i,
   output logic                           clear_start_o,
   output logic [7:0]                     new_y_o,
   output logic                           load_start_o,
   output obm_object_t                    load_object_o,
   output logic                           busy_o,
   output logic                           done_o,
   output logic                           late_o,
   output logic                           overflow_o
);

   localparam int AW = $clog2(NUM_OBJECTS);

   typedef enum logic [2:0] {
      IDLE, CLEAR_REQ, CLEAR_WAIT, FETCH, CHECK, LOAD_REQ, LOAD_WAIT, DONE
   } state_t;

   state_t      state, state_n;
   logic [AW-1:0] idx, idx_n;
   logic [7:0]  line_y, line_y_n;
   logic        first, first_n;
   obm_object_t obj_n;
   logic        hit, room, last;

`ifdef OBJ_LIMIT_EN
   localparam int CW = $clog2(MAX_PER_LINE + 1);
   logic [CW-1:0] cnt, cnt_n;
   logic          ovf, ovf_n;
   assign room       = cnt != CW'(MAX_PER_LINE);
   assign overflow_o = ovf;
`else
   assign room       = 1'b1;
   assign overflow_o = 1'b0;
`endif

   assign hit        = object_on_line(line_y, obm_object_i);
   assign last       = idx == AW'(NUM_OBJECTS - 1);
   assign obm_addr_o = idx;
   assign new_y_o    = line_y;
   assign busy_o     = state != IDLE;
   assign done_o     = state == DONE;
   assign late_o     = line_start_i && busy_o;

   always_comb begin
      state_n       = state;
      idx_n         = idx;
      line_y_n      = line_y;
      first_n       = 1'b0;
      obj_n         = load_object_o;
      clear_start_o = 1'b0;
      load_start_o  = 1'b0;
`ifdef OBJ_LIMIT_EN
      cnt_n         = cnt;
      ovf_n         = ovf;
`endif
      case (state)
         IDLE: if (line_start_i) begin
            state_n  = CLEAR_REQ;
            line_y_n = next_y_i;
            idx_n    = '0;
`ifdef OBJ_LIMIT_EN
            cnt_n    = '0;
            ovf_n    = 1'b0;
`endif
         end
         CLEAR_REQ: if (scanline_ready_i) begin
            clear_start_o = 1'b1;
            first_n       = 1'b1;
            state_n       = CLEAR_WAIT;
         end
         CLEAR_WAIT: state_n = (!first && scanline_ready_i) ? FETCH : CLEAR_WAIT;
         FETCH: state_n = CHECK;
         CHECK: if (hit && room) begin
            obj_n   = obm_object_i;
            state_n = LOAD_REQ;
`ifdef OBJ_LIMIT_EN
            cnt_n   = cnt + 1'b1;
`endif
         end else begin
            // the final index is never incremented, so idx cannot wrap back to 0
            state_n = last ? DONE : FETCH;
            idx_n   = last ? idx : idx + 1'b1;
`ifdef OBJ_LIMIT_EN
            ovf_n   = ovf || hit;
`endif
         end
         LOAD_REQ: if (scanline_ready_i) begin
            load_start_o = 1'b1;
            first_n      = 1'b1;
            state_n      = LOAD_WAIT;
         end
         LOAD_WAIT: if (!first && scanline_ready_i) begin
            state_n = last ? DONE : FETCH;
            idx_n   = last ? idx : idx + 1'b1;
         end
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge gpu_clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         idx           <= '0;
         line_y        <= '0;
         first         <= 1'b0;
         load_object_o <= '0;
`ifdef OBJ_LIMIT_EN
         cnt           <= '0;
         ovf           <= 1'b0;
`endif
      end else begin
         state         <= state_n;
         idx           <= idx_n;
         line_y        <= line_y_n;
         first         <= first_n;
         load_object_o <= obj_n;
`ifdef OBJ_LIMIT_EN
         cnt           <= cnt_n;
         ovf           <= ovf_n;
`endif
      end
   end

endmodule

// File: tb/tb_object_scanline_sequencer.sv
// tb_object_scanline_sequencer: table, directed and random lines checked against a list-based model.
module tb_object_scanline_sequencer;
   import object_scanline_sequencer_pkg::*;

   localparam int N = 64;

   logic        gpu_clk = 1'b0;
   logic        rst = 1'b1;
   logic        line_start_i = 1'b0;
   logic [7:0]  next_y_i = '0;
   logic [5:0]  obm_addr_o;
   obm_object_t obm_object_i;
   logic        scanline_ready_i;
   logic        clear_start_o, load_start_o, busy_o, done_o, late_o, overflow_o;
   logic [7:0]  new_y_o;
   obm_object_t load_object_o;

   object_scanline_sequencer dut (
      .gpu_clk(gpu_clk), .rst(rst), .line_start_i(line_start_i), .next_y_i(next_y_i),
      .obm_addr_o(obm_addr_o), .obm_object_i(obm_object_i), .scanline_ready_i(scanline_ready_i),
      .clear_start_o(clear_start_o), .new_y_o(new_y_o), .load_start_o(load_start_o),
      .load_object_o(load_object_o), .busy_o(busy_o), .done_o(done_o), .late_o(late_o),
      .overflow_o(overflow_o)
   );

   always #5 gpu_clk = ~gpu_clk;

   obm_object_t mem [N];
   always @(posedge gpu_clk) obm_object_i <= mem[obm_addr_o];

   // scanline stand-in: after each start pulse ready drops for lat cycles (lat<0: random 0..3)
   int lat = 0;
   int busy_cnt = 0;
   always @(posedge gpu_clk)
      if (clear_start_o || load_start_o) busy_cnt <= (lat < 0) ? int'($urandom_range(0, 3)) : lat;
      else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
   assign scanline_ready_i = busy_cnt == 0;

   int errors = 0, checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   int clears[$];
   int loads[$];
   int done_cnt = 0, late_cnt = 0, stab = 0;
   obm_object_t last_obj = '0;

   always @(negedge gpu_clk)
      if (rst) stab <= 0;
      else begin
         if (stab > 0) begin
            check("load_object_o held", load_object_o, last_obj);
            stab <= stab - 1;
         end
         if (clear_start_o) clears.push_back(int'(new_y_o));
         if (load_start_o) begin
            loads.push_back(int'(load_object_o.x));
            last_obj <= load_object_o;
            stab <= 3;
         end
         if (done_o) done_cnt <= done_cnt + 1;
         if (late_o) late_cnt <= late_cnt + 1;
      end

   int exp_ids[$];

   task automatic model(input int y);
      exp_ids.delete();
      for (int i = 0; i < N; i++)
         if (y >= int'(mem[i].y) && y <= int'(mem[i].y) + 7) begin
`ifdef OBJ_LIMIT_EN
            if (exp_ids.size() < 8) exp_ids.push_back(i);
`else
            exp_ids.push_back(i);
`endif
         end
   endtask

   task automatic set_empty();
      for (int i = 0; i < N; i++) begin
         mem[i].x       = 8'(i);
         mem[i].y       = 8'd200;
         mem[i].tile    = 8'(i * 3 + 1);
         mem[i].palette = 4'(i);
         mem[i].flip_x  = 1'b1;
         mem[i].flip_y  = 1'b0;
         mem[i].layer   = 2'(i);
      end
   endtask

   task automatic pulse(input int y);
      @(posedge gpu_clk); #1;
      line_start_i = 1'b1;
      next_y_i     = 8'(y);
      @(posedge gpu_clk); #1;
      line_start_i = 1'b0;
   endtask

   task automatic wait_done(input int d0);
      int c;
      c = 0;
      while (done_cnt == d0 && c < 4000) begin
         @(posedge gpu_clk); #1;
         c++;
      end
      check("done within budget", done_cnt != d0, 1'b1);
   endtask

   task automatic finish_line(input int y, input int d0);
      wait_done(d0);
      check("idle after done", busy_o, 1'b0);
      check("done pulses", done_cnt - d0, 1);
      model(y);
      check("clear count", clears.size(), 1);
      if (clears.size() > 0) check("clear y", clears[0], y);
      check("load count", loads.size(), exp_ids.size());
      for (int i = 0; i < loads.size() && i < exp_ids.size(); i++) check("load order", loads[i], exp_ids[i]);
   endtask

   task automatic run_line(input int y);
      int d0;
      clears.delete();
      loads.delete();
      d0 = done_cnt;
      pulse(y);
      finish_line(y, d0);
   endtask

   typedef struct {
      int line_y;
      int obj_y;
      int idx;
      bit hit;
   } vec_t;

   vec_t tbl[12];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int d0, l0, c;
      tbl[0]  = '{10, 10, 5, 1};
      tbl[1]  = '{10, 3, 7, 1};
      tbl[2]  = '{10, 2, 9, 0};
      tbl[3]  = '{255, 250, 0, 1};
      tbl[4]  = '{2, 250, 0, 0};
      tbl[5]  = '{0, 0, 1, 1};
      tbl[6]  = '{7, 0, 2, 1};
      tbl[7]  = '{8, 0, 3, 0};
      tbl[8]  = '{255, 248, 63, 1};
      tbl[9]  = '{250, 250, 63, 1};
      tbl[10] = '{249, 250, 20, 0};
      tbl[11] = '{100, 93, 33, 1};
      set_empty();
      repeat (3) @(posedge gpu_clk);
      #1;
      check("reset busy_o", busy_o, 0);
      check("reset done_o", done_o, 0);
      check("reset clear_start_o", clear_start_o, 0);
      check("reset load_start_o", load_start_o, 0);
      check("reset obm_addr_o", obm_addr_o, 0);
      check("reset new_y_o", new_y_o, 0);
      check("reset load_object_o", load_object_o, 0);
      check("reset overflow_o", overflow_o, 0);
      rst = 1'b0;

      run_line(10);
      check("empty OBM loads", loads.size(), 0);

      for (int t = 0; t < 12; t++) begin
         set_empty();
         mem[tbl[t].idx].y = 8'(tbl[t].obj_y);
         run_line(tbl[t].line_y);
         check("table hit", loads.size(), int'(tbl[t].hit));
         if (tbl[t].hit && loads.size() > 0) check("table idx", loads[loads.size() - 1], tbl[t].idx);
      end

      set_empty();
      mem[3].y  = 8'd8;
      mem[40].y = 8'd15;
      lat = 3;
      run_line(15);
      if (loads.size() == 2) begin
         check("first load is 3", loads[0], 3);
         check("second load is 40", loads[1], 40);
      end else check("two loads", loads.size(), 2);

      set_empty();
      mem[10].y = 8'd30;
      clears.delete();
      loads.delete();
      d0 = done_cnt;
      l0 = late_cnt;
      pulse(30);
      c = 0;
      while (clears.size() == 0 && c < 50) begin
         @(posedge gpu_clk); #1;
         c++;
      end
      check("busy during clear wait", busy_o, 1'b1);
      line_start_i = 1'b1;
      next_y_i     = 8'd100;
      @(posedge gpu_clk); #1;
      line_start_i = 1'b0;
      finish_line(30, d0);
      check("late pulses", late_cnt - l0, 1);
      repeat (20) @(posedge gpu_clk);
      #1;
      check("no line for dropped start", clears.size(), 1);

      set_empty();
      mem[5].y = 8'd40;
      clears.delete();
      loads.delete();
      pulse(40);
      c = 0;
      while (loads.size() == 0 && c < 400) begin
         @(posedge gpu_clk); #1;
         c++;
      end
      check("load before reset", loads.size(), 1);
      rst = 1'b1;
      #1;
      check("mid-reset busy_o", busy_o, 0);
      check("mid-reset load_start_o", load_start_o, 0);
      check("mid-reset load_object_o", load_object_o, 0);
      check("mid-reset new_y_o", new_y_o, 0);
      check("mid-reset obm_addr_o", obm_addr_o, 0);
      @(posedge gpu_clk); #1;
      check("mid-reset done_o", done_o, 0);
      rst = 1'b0;
      clears.delete();
      loads.delete();
      d0 = done_cnt;
      repeat (30) @(posedge gpu_clk);
      #1;
      check("no clear after reset", clears.size(), 0);
      check("no load after reset", loads.size(), 0);
      check("no done after reset", done_cnt - d0, 0);
      check("idle after reset", busy_o, 0);

      set_empty();
      lat = 1;
      for (int i = 0; i < 10; i++) mem[i].y = 8'd20;
      run_line(20);
`ifdef OBJ_LIMIT_EN
      check("limited loads", loads.size(), 8);
      check("overflow set", overflow_o, 1);
      repeat (5) @(posedge gpu_clk);
      #1;
      check("overflow held", overflow_o, 1);
      run_line(100);
      check("overflow cleared", overflow_o, 0);
`else
      check("unlimited loads", loads.size(), 10);
      check("overflow tied low", overflow_o, 0);
`endif

      lat = -1;
      for (int r = 0; r < 16; r++) begin
         int ly;
         ly = int'($urandom_range(0, 255));
         for (int i = 0; i < N; i++)
            mem[i].y = (r % 2 == 0) ? 8'($urandom_range(0, 255))
                                    : 8'($urandom_range(ly > 12 ? ly - 12 : 0, ly < 252 ? ly + 3 : 255));
         run_line(ly);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
